// File: rtl/lsu_mem_if.sv
// Single-beat request/acknowledge data-memory port between the load/store unit
// (master) and the data memory (slave).
interface lsu_mem_if #(
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);
  logic                  o_mem_req;
  logic                  o_mem_we;
  logic [DATA_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic [BE_WIDTH-1:0]   o_mem_be;
  logic                  i_mem_ack;
  logic [DATA_WIDTH-1:0] i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    input  i_mem_ack, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    output i_mem_ack, i_mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV64 memory-access stage: one load or store per command over a single-beat
// memory port, with lane alignment, load extension and error flagging.
module load_store_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_start,
  input  logic                  i_is_load,
  input  logic                  i_is_store,
  input  logic [2:0]            i_funct3,
  input  logic [DATA_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_store_data,
  output logic                  o_ready,
  lsu_mem_if.master             mem,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic                  o_misaligned,
  output logic                  o_illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  is_load_q, is_load_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [2:0]            off_q, off_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_WIDTH-1:0]   mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                  misaligned_q, misaligned_d;
  logic                  illegal_q, illegal_d;
  logic                  illegal_s;
  logic                  misaligned_s;

  function automatic logic cmd_illegal(input logic ld, input logic st, input logic [2:0] f3);
    logic bad;
    bad = 1'b0;
    if (ld == st) begin
      bad = 1'b1;
    end else if (ld) begin
      bad = (f3 == 3'b111);
    end else begin
      bad = f3[2];
    end
    return bad;
  endfunction

  function automatic logic addr_misaligned(input logic [1:0] size, input logic [2:0] a);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = a[0];
      2'b10:   mis = |a[1:0];
      2'b11:   mis = |a[2:0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [BE_WIDTH-1:0] size_mask(input logic [1:0] size);
    logic [BE_WIDTH-1:0] m;
    case (size)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      2'b11:   m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] rdata,
                                                        input logic [2:0] off,
                                                        input logic [2:0] f3);
    logic [DATA_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0] r;
    s = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{(DATA_WIDTH-8){s[7]}}, s[7:0]};
      3'b001:  r = {{(DATA_WIDTH-16){s[15]}}, s[15:0]};
      3'b010:  r = {{(DATA_WIDTH-32){s[31]}}, s[31:0]};
      3'b011:  r = s;
      3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, s[7:0]};
      3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, s[15:0]};
      3'b110:  r = {{(DATA_WIDTH-32){1'b0}}, s[31:0]};
      default: r = {DATA_WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  assign illegal_s    = cmd_illegal(i_is_load, i_is_store, i_funct3);
  assign misaligned_s = !illegal_s && addr_misaligned(i_funct3[1:0], i_addr[2:0]);

  // Outputs decode straight from registers; reset drops o_mem_req immediately.
  assign o_ready         = (state_q == IDLE);
  assign o_done          = (state_q == DONE);
  assign mem.o_mem_req   = (state_q == REQ);
  assign mem.o_mem_we    = mem_we_q;
  assign mem.o_mem_addr  = mem_addr_q;
  assign mem.o_mem_wdata = mem_wdata_q;
  assign mem.o_mem_be    = mem_be_q;
  assign o_load_data     = load_data_q;
  assign o_misaligned    = misaligned_q;
  assign o_illegal       = illegal_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= IDLE;
      is_load_q    <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 3'b000;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {DATA_WIDTH{1'b0}};
      mem_wdata_q  <= {DATA_WIDTH{1'b0}};
      mem_be_q     <= {BE_WIDTH{1'b0}};
      load_data_q  <= {DATA_WIDTH{1'b0}};
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_load_q    <= is_load_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      load_data_q  <= load_data_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d      = state_q;
    is_load_d    = is_load_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    load_data_d  = load_data_q;
    misaligned_d = misaligned_q;
    illegal_d    = illegal_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          is_load_d    = i_is_load;
          funct3_d     = i_funct3;
          off_d        = i_addr[2:0];
          mem_we_d     = i_is_store;
          mem_addr_d   = {i_addr[DATA_WIDTH-1:3], 3'b000};
          illegal_d    = illegal_s;
          misaligned_d = misaligned_s;
          if (i_is_store) begin
            mem_wdata_d = i_store_data << {i_addr[2:0], 3'b000};
            mem_be_d    = size_mask(i_funct3[1:0]) << i_addr[2:0];
          end else begin
            mem_wdata_d = {DATA_WIDTH{1'b0}};
            mem_be_d    = {BE_WIDTH{1'b1}};
          end
          // Errors complete without ever raising a memory request.
          if (illegal_s || misaligned_s) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem.i_mem_ack) begin
          state_d = DONE;
          if (is_load_q) begin
            load_data_d = load_extend(mem.i_mem_rdata, off_q, funct3_q);
          end else begin
            load_data_d = load_data_q;
          end
        end else begin
          state_d = REQ;
        end
      end
      DONE: begin
        state_d      = IDLE;
        misaligned_d = 1'b0;
        illegal_d    = 1'b0;
      end
      default: begin
        state_d      = IDLE;
        misaligned_d = 1'b0;
        illegal_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; inputs change and outputs
// are sampled on the falling edge, away from the active rising edge.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_is_load = 1'b0;
  logic        i_is_store = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [63:0] i_addr = 64'h0;
  logic [63:0] i_store_data = 64'h0;
  logic        o_ready;
  logic        o_done;
  logic [63:0] o_load_data;
  logic        o_misaligned;
  logic        o_illegal;
  int          checks = 0;
  int          failures = 0;

  lsu_mem_if #(.DATA_WIDTH(64)) mem_bus ();

  load_store_unit #(.DATA_WIDTH(64)) dut (
    .clk(clk), .arst(arst), .i_start(i_start), .i_is_load(i_is_load),
    .i_is_store(i_is_store), .i_funct3(i_funct3), .i_addr(i_addr),
    .i_store_data(i_store_data), .o_ready(o_ready), .mem(mem_bus),
    .o_done(o_done), .o_load_data(o_load_data), .o_misaligned(o_misaligned),
    .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  // Presents a command for one cycle (cycle T) and returns at cycle T+1.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] sd);
    i_start = 1'b1; i_is_load = ld; i_is_store = st; i_funct3 = f3;
    i_addr = addr; i_store_data = sd;
    @(negedge clk);
    i_start = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
  endtask

  task automatic test_reset();
    mem_bus.i_mem_ack = 1'b0; mem_bus.i_mem_rdata = 64'h0;
    @(negedge clk); @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0h exp=1", o_ready); end
    checks++; if (mem_bus.o_mem_req !== 1'b0 || mem_bus.o_mem_we !== 1'b0) begin failures++; $display("FAIL rst_req_we got=%0b%0b exp=00", mem_bus.o_mem_req, mem_bus.o_mem_we); end
    checks++; if (mem_bus.o_mem_addr !== 64'h0 || mem_bus.o_mem_wdata !== 64'h0 || mem_bus.o_mem_be !== 8'h00) begin failures++; $display("FAIL rst_bus got=%h/%h/%h exp=0/0/0", mem_bus.o_mem_addr, mem_bus.o_mem_wdata, mem_bus.o_mem_be); end
    checks++; if (o_load_data !== 64'h0 || o_done !== 1'b0 || o_misaligned !== 1'b0 || o_illegal !== 1'b0) begin failures++; $display("FAIL rst_result got=%h %0b%0b%0b exp=0 000", o_load_data, o_done, o_misaligned, o_illegal); end
    arst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_sign();
    logic [2:0]  f3  [2] = '{3'b000, 3'b100};
    logic [63:0] exp [2] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080};
    for (int k = 0; k < 2; k++) begin
      issue(1'b1, 1'b0, f3[k], 64'h1003, 64'h0);
      checks++; if (mem_bus.o_mem_req !== 1'b1 || mem_bus.o_mem_we !== 1'b0) begin failures++; $display("FAIL ld_req_we[%0d] got=%0b%0b exp=10", k, mem_bus.o_mem_req, mem_bus.o_mem_we); end
      checks++; if (mem_bus.o_mem_addr !== 64'h1000 || mem_bus.o_mem_be !== 8'hFF) begin failures++; $display("FAIL ld_addr_be[%0d] got=%h/%h exp=1000/ff", k, mem_bus.o_mem_addr, mem_bus.o_mem_be); end
      mem_bus.i_mem_ack = 1'b1; mem_bus.i_mem_rdata = 64'h0000_0000_8000_0000;
      @(negedge clk);
      mem_bus.i_mem_ack = 1'b0;
      checks++; if (o_done !== 1'b1 || o_misaligned !== 1'b0 || o_illegal !== 1'b0) begin failures++; $display("FAIL ld_done[%0d] got=%0b%0b%0b exp=100", k, o_done, o_misaligned, o_illegal); end
      checks++; if (o_load_data !== exp[k]) begin failures++; $display("FAIL ld_data[%0d] got=%h exp=%h", k, o_load_data, exp[k]); end
      @(negedge clk);
      checks++; if (o_ready !== 1'b1 || o_done !== 1'b0) begin failures++; $display("FAIL ld_idle[%0d] got=%0b%0b exp=10", k, o_ready, o_done); end
    end
  endtask

  task automatic test_store_align();
    issue(1'b0, 1'b1, 3'b001, 64'h2006, 64'h1234);
    for (int c = 1; c <= 4; c++) begin
      checks++; if (mem_bus.o_mem_req !== 1'b1 || mem_bus.o_mem_we !== 1'b1 || o_done !== 1'b0) begin failures++; $display("FAIL st_hold[%0d] req/we/done got=%0b%0b%0b exp=110", c, mem_bus.o_mem_req, mem_bus.o_mem_we, o_done); end
      checks++; if (mem_bus.o_mem_wdata !== 64'h1234_0000_0000_0000 || mem_bus.o_mem_be !== 8'hC0 || mem_bus.o_mem_addr !== 64'h2000) begin failures++; $display("FAIL st_lane[%0d] got=%h/%h/%h exp=1234000000000000/c0/2000", c, mem_bus.o_mem_wdata, mem_bus.o_mem_be, mem_bus.o_mem_addr); end
      if (c == 4) begin mem_bus.i_mem_ack = 1'b1; mem_bus.i_mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF; end
      @(negedge clk);
    end
    mem_bus.i_mem_ack = 1'b0;
    checks++; if (o_done !== 1'b1 || mem_bus.o_mem_req !== 1'b0) begin failures++; $display("FAIL st_done got=%0b req=%0b exp=1 0", o_done, mem_bus.o_mem_req); end
    checks++; if (o_load_data !== 64'h80) begin failures++; $display("FAIL st_ld_kept got=%h exp=80", o_load_data); end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    issue(1'b1, 1'b0, 3'b010, 64'h3002, 64'h0);
    checks++; if (o_done !== 1'b1 || o_misaligned !== 1'b1 || o_illegal !== 1'b0 || mem_bus.o_mem_req !== 1'b0) begin failures++; $display("FAIL mis_lw got done/mis/ill/req=%0b%0b%0b%0b exp=1100", o_done, o_misaligned, o_illegal, mem_bus.o_mem_req); end
    @(negedge clk);
    checks++; if (o_ready !== 1'b1 || mem_bus.o_mem_req !== 1'b0 || o_misaligned !== 1'b0) begin failures++; $display("FAIL mis_after got ready/req/mis=%0b%0b%0b exp=100", o_ready, mem_bus.o_mem_req, o_misaligned); end
    issue(1'b0, 1'b1, 3'b000, 64'h3007, 64'hAB);
    checks++; if (mem_bus.o_mem_req !== 1'b1 || mem_bus.o_mem_be !== 8'h80 || mem_bus.o_mem_wdata !== 64'hAB00_0000_0000_0000) begin failures++; $display("FAIL sb_lane got req=%0b be=%h wd=%h exp=1 80 ab00000000000000", mem_bus.o_mem_req, mem_bus.o_mem_be, mem_bus.o_mem_wdata); end
    mem_bus.i_mem_ack = 1'b1;
    @(negedge clk);
    mem_bus.i_mem_ack = 1'b0;
    checks++; if (o_done !== 1'b1 || o_misaligned !== 1'b0 || o_load_data !== 64'h80) begin failures++; $display("FAIL sb_done got done=%0b mis=%0b ld=%h exp=1 0 80", o_done, o_misaligned, o_load_data); end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic        ld [3] = '{1'b1, 1'b1, 1'b0};
    logic        st [3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0]  f3 [3] = '{3'b111, 3'b011, 3'b100};
    logic [63:0] ad [3] = '{64'h0, 64'h5, 64'h3};
    for (int k = 0; k < 3; k++) begin
      issue(ld[k], st[k], f3[k], ad[k], 64'h55);
      checks++; if (o_done !== 1'b1 || o_illegal !== 1'b1 || o_misaligned !== 1'b0 || mem_bus.o_mem_req !== 1'b0) begin failures++; $display("FAIL ill[%0d] got done/ill/mis/req=%0b%0b%0b%0b exp=1100", k, o_done, o_illegal, o_misaligned, mem_bus.o_mem_req); end
      @(negedge clk);
      checks++; if (o_ready !== 1'b1 || o_illegal !== 1'b0 || o_load_data !== 64'h80) begin failures++; $display("FAIL ill_after[%0d] got ready=%0b ill=%0b ld=%h exp=1 0 80", k, o_ready, o_illegal, o_load_data); end
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b0, 3'b101, 64'h6, 64'h0);
    mem_bus.i_mem_ack = 1'b1; mem_bus.i_mem_rdata = 64'hBEEF_0000_0000_0000;
    @(negedge clk);
    mem_bus.i_mem_ack = 1'b0;
    checks++; if (o_done !== 1'b1 || o_load_data !== 64'hBEEF) begin failures++; $display("FAIL b2b_lhu got done=%0b ld=%h exp=1 beef", o_done, o_load_data); end
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b010, 64'h4, 64'h0);
    checks++; if (mem_bus.o_mem_req !== 1'b1 || mem_bus.o_mem_addr !== 64'h0) begin failures++; $display("FAIL b2b_accept got req=%0b addr=%h exp=1 0", mem_bus.o_mem_req, mem_bus.o_mem_addr); end
    mem_bus.i_mem_ack = 1'b1; mem_bus.i_mem_rdata = 64'h8000_0001_0000_0000;
    @(negedge clk);
    mem_bus.i_mem_ack = 1'b0;
    checks++; if (o_done !== 1'b1 || o_load_data !== 64'hFFFF_FFFF_8000_0001) begin failures++; $display("FAIL b2b_lw got done=%0b ld=%h exp=1 ffffffff80000001", o_done, o_load_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_req();
    issue(1'b1, 1'b0, 3'b011, 64'h4000, 64'h0);
    checks++; if (mem_bus.o_mem_req !== 1'b1) begin failures++; $display("FAIL arst_pre_req got=%0b exp=1", mem_bus.o_mem_req); end
    @(negedge clk);
    arst = 1'b1;
    #1;
    checks++; if (mem_bus.o_mem_req !== 1'b0 || o_ready !== 1'b1) begin failures++; $display("FAIL arst_drop got req=%0b ready=%0b exp=0 1", mem_bus.o_mem_req, o_ready); end
    @(negedge clk);
    arst = 1'b0;
    mem_bus.i_mem_ack = 1'b1; mem_bus.i_mem_rdata = 64'h1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_bus.i_mem_ack = 1'b0;
      checks++; if (o_done !== 1'b0 || o_ready !== 1'b1 || mem_bus.o_mem_req !== 1'b0) begin failures++; $display("FAIL arst_after[%0d] got done/ready/req=%0b%0b%0b exp=010", c, o_done, o_ready, mem_bus.o_mem_req); end
    end
    checks++; if (o_load_data !== 64'h0) begin failures++; $display("FAIL arst_ld got=%h exp=0", o_load_data); end
  endtask

  task automatic test_busy();
    int dones = 0;
    issue(1'b1, 1'b0, 3'b011, 64'h4008, 64'h0);
    i_start = 1'b1; i_is_store = 1'b1; i_funct3 = 3'b000; i_addr = 64'h9001; i_store_data = 64'hFF;
    @(negedge clk);
    checks++; if (mem_bus.o_mem_req !== 1'b1 || mem_bus.o_mem_we !== 1'b0 || mem_bus.o_mem_addr !== 64'h4008) begin failures++; $display("FAIL busy_hold got req=%0b we=%0b addr=%h exp=1 0 4008", mem_bus.o_mem_req, mem_bus.o_mem_we, mem_bus.o_mem_addr); end
    @(negedge clk);
    i_start = 1'b0; i_is_store = 1'b0;
    mem_bus.i_mem_ack = 1'b1; mem_bus.i_mem_rdata = 64'h1122_3344_5566_7788;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mem_bus.i_mem_ack = 1'b0;
      if (o_done === 1'b1) dones++;
    end
    checks++; if (dones !== 1) begin failures++; $display("FAIL busy_dones got=%0d exp=1", dones); end
    checks++; if (o_load_data !== 64'h1122_3344_5566_7788) begin failures++; $display("FAIL busy_ld got=%h exp=1122334455667788", o_load_data); end
  endtask

  initial begin
    test_reset();
    test_load_sign();
    test_store_align();
    test_misaligned();
    test_illegal();
    test_back_to_back();
    test_reset_mid_req();
    test_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
